branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/branch_predictor_sat_counter.sv | 22 ++
 rtl/branch_predictor.sv | 85 ++++++++
 tb/tb_branch_predictor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states,
// the PC increment and the default table index width.
package branch_predictor_pkg;

    // Default log2 of the branch history table depth
    localparam int unsigned BP_IDX_BITS = 6;

    // Sequential fetch increment
    localparam logic [31:0] PC_INC = 32'd4;

    // 2-bit saturating counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of one 2-bit saturating counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_t state,
    input  logic taken,
    output ctr_t next_state
);

    // Step towards ST on taken, towards SNT on not-taken, saturating at both ends
    always_comb begin
        next_state = state;
        unique case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC producer: bimodal table of 2-bit counters predicting ID branches,
// trained by EX resolution, with misprediction recovery and flush.
// Optional macro BP_GSHARE_EN: XOR a global history register into the index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS   = BP_IDX_BITS,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_i,
    input  logic        id_branch_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_target_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_taken_i,
    input  logic        ex_pred_i,
    output logic [31:0] pc_next_o,
    output logic        pred_taken_o,
    output logic        flush_o
);

    localparam int unsigned TBL_SIZE = 1 << IDX_BITS;

    ctr_t                table_q [TBL_SIZE];
    ctr_t                ctr_next;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                mispredict;
    logic                unused_id_pc;

    assign unused_id_pc = ^{id_pc_i[31:IDX_BITS+2], id_pc_i[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    // Global history: shift in each resolved outcome
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ghr <= '0;
        else if (ex_valid_i)
            ghr <= {ghr[IDX_BITS-2:0], ex_taken_i};
    end

    // Prediction and update both hash with the current history value
    assign rd_idx = id_pc_i[IDX_BITS+1:2] ^ ghr;
    assign wr_idx = ex_pc_i[IDX_BITS+1:2] ^ ghr;
`else
    assign rd_idx = id_pc_i[IDX_BITS+1:2];
    assign wr_idx = ex_pc_i[IDX_BITS+1:2];
`endif

    bp_sat_counter u_sat_counter (
        .state      (table_q[wr_idx]),
        .taken      (ex_taken_i),
        .next_state (ctr_next)
    );

    // Counter table: asynchronous reinit, train the resolved entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < TBL_SIZE; i++)
                table_q[i] <= ctr_t'(INIT_STATE);
        end else if (ex_valid_i) begin
            table_q[wr_idx] <= ctr_next;
        end
    end

    // Prediction, recovery select and flush; mispredict held off while in reset
    always_comb begin
        pred_taken_o = id_branch_i & table_q[rd_idx][1];
        mispredict   = rst_n_i & ex_valid_i & (ex_taken_i != ex_pred_i);
        flush_o      = mispredict;
        if (mispredict)
            pc_next_o = ex_taken_i ? ex_target_i : (ex_pc_i + PC_INC);
        else if (pred_taken_o)
            pc_next_o = id_target_i;
        else
            pc_next_o = pc_i + PC_INC;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] pc_i;
    logic        id_branch_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_target_i;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_taken_i;
    logic        ex_pred_i;
    logic [31:0] pc_next_o;
    logic        pred_taken_o;
    logic        flush_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    branch_predictor #(
        .IDX_BITS   (6),
        .INIT_STATE (2'b01)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .pc_i         (pc_i),
        .id_branch_i  (id_branch_i),
        .id_pc_i      (id_pc_i),
        .id_target_i  (id_target_i),
        .ex_valid_i   (ex_valid_i),
        .ex_pc_i      (ex_pc_i),
        .ex_target_i  (ex_target_i),
        .ex_taken_i   (ex_taken_i),
        .ex_pred_i    (ex_pred_i),
        .pc_next_o    (pc_next_o),
        .pred_taken_o (pred_taken_o),
        .flush_o      (flush_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One correctly-predicted EX update, applied at the next rising edge
    task automatic ex_update(input logic [31:0] pc, input logic taken);
        ex_valid_i  = 1'b1;
        ex_pc_i     = pc;
        ex_target_i = 32'h400;
        ex_taken_i  = taken;
        ex_pred_i   = taken;
        @(posedge clk_i);
        #1;
        ex_valid_i  = 1'b0;
    endtask

    // ID lookup, settle combinational outputs
    task automatic lookup(input logic [31:0] pc, input logic [31:0] target);
        id_branch_i = 1'b1;
        id_pc_i     = pc;
        id_target_i = target;
        #1;
    endtask

    initial begin
        rst_n_i     = 1'b0;
        pc_i        = 32'h44;
        id_branch_i = 1'b1;
        id_pc_i     = 32'h40;
        id_target_i = 32'h80;
        ex_valid_i  = 1'b0;
        ex_pc_i     = '0;
        ex_target_i = '0;
        ex_taken_i  = 1'b0;
        ex_pred_i   = 1'b0;
        #1;
        check_eq("rst_pred", 32'(pred_taken_o), 32'd0);
        check_eq("rst_pc_next", pc_next_o, 32'h48);
        check_eq("rst_flush", 32'(flush_o), 32'd0);
        ex_valid_i = 1'b1; ex_pc_i = 32'h40; ex_target_i = 32'h80;
        ex_taken_i = 1'b1; ex_pred_i = 1'b0;
        #1;
        check_eq("rst_flush_gated", 32'(flush_o), 32'd0);
        ex_valid_i = 1'b0;

`ifdef BP_GSHARE_EN
        check_eq("gs_ghr_rst", 32'(dut.ghr), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ex_update(32'h40, 1'b1);
        ex_update(32'h40, 1'b0);
        ex_update(32'h40, 1'b1);
        check_eq("gs_ghr_101", 32'(dut.ghr[2:0]), 32'b101);
        // idx(0x54)=21, 21^5=16 -> trained WT by first update
        lookup(32'h54, 32'h80);
        check_eq("gs_pred_hashed", 32'(pred_taken_o), 32'd1);
        // idx(0x40)=16, 16^5=21 -> untouched WNT
        lookup(32'h40, 32'h80);
        check_eq("gs_pred_fresh", 32'(pred_taken_o), 32'd0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("gs_ghr_midrst", 32'(dut.ghr), 32'd0);
        rst_n_i = 1'b1;
`else
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check_eq("post_rst_pred", 32'(pred_taken_o), 32'd0);
        check_eq("post_rst_pc_next", pc_next_o, 32'h48);

        // Train 0x40 taken twice with not-taken predictions: WNT->WT->ST
        @(negedge clk_i);
        id_branch_i = 1'b0;
        ex_valid_i = 1'b1; ex_pc_i = 32'h40; ex_target_i = 32'h80;
        ex_taken_i = 1'b1; ex_pred_i = 1'b0;
        #1;
        check_eq("train1_flush", 32'(flush_o), 32'd1);
        check_eq("train1_pc_next", pc_next_o, 32'h80);
        @(posedge clk_i); #1;
        check_eq("train2_flush", 32'(flush_o), 32'd1);
        check_eq("train2_pc_next", pc_next_o, 32'h80);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        lookup(32'h40, 32'h80);
        check_eq("trained_pred", 32'(pred_taken_o), 32'd1);
        check_eq("trained_pc_next", pc_next_o, 32'h80);
        check_eq("trained_flush", 32'(flush_o), 32'd0);
        lookup(32'h143, 32'h80);
        check_eq("alias_pred", 32'(pred_taken_o), 32'd1);

        // Saturation on 0x20 (idx 8)
        id_branch_i = 1'b0;
        repeat (5) ex_update(32'h20, 1'b1);
        ex_update(32'h20, 1'b0);
        lookup(32'h20, 32'h400);
        check_eq("sat_st_to_wt", 32'(pred_taken_o), 32'd1);
        ex_update(32'h20, 1'b0);
        lookup(32'h20, 32'h400);
        check_eq("sat_wt_to_wnt", 32'(pred_taken_o), 32'd0);
        repeat (5) ex_update(32'h20, 1'b0);
        ex_update(32'h20, 1'b1);
        lookup(32'h20, 32'h400);
        check_eq("sat_snt_to_wnt", 32'(pred_taken_o), 32'd0);
        ex_update(32'h20, 1'b1);
        lookup(32'h20, 32'h400);
        check_eq("sat_wnt_to_wt", 32'(pred_taken_o), 32'd1);

        // Mispredict overrides a taken ID prediction
        @(negedge clk_i);
        pc_i = 32'h44;
        lookup(32'h40, 32'h80);
        ex_valid_i = 1'b1; ex_pc_i = 32'h100; ex_target_i = 32'h300;
        ex_taken_i = 1'b0; ex_pred_i = 1'b1;
        #1;
        check_eq("prio_pc_next", pc_next_o, 32'h104);
        check_eq("prio_flush", 32'(flush_o), 32'd1);
        check_eq("prio_pred", 32'(pred_taken_o), 32'd1);
        ex_pred_i = 1'b0;
        #1;
        check_eq("prio_correct_pc_next", pc_next_o, 32'h80);
        check_eq("prio_correct_flush", 32'(flush_o), 32'd0);
        ex_taken_i = 1'b1;
        #1;
        check_eq("prio_taken_pc_next", pc_next_o, 32'h300);
        ex_valid_i = 1'b0;

        // Same-index read and write on 0x60 (fresh WNT)
        @(negedge clk_i);
        lookup(32'h60, 32'h90);
        ex_valid_i = 1'b1; ex_pc_i = 32'h60; ex_target_i = 32'h90;
        ex_taken_i = 1'b1; ex_pred_i = 1'b0;
        #1;
        check_eq("rw_same_cycle", 32'(pred_taken_o), 32'd0);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        #1;
        check_eq("rw_next_cycle", 32'(pred_taken_o), 32'd1);
        check_eq("rw_next_pc_next", pc_next_o, 32'h90);

        // 32-bit wrap of the increment
        id_branch_i = 1'b0;
        pc_i = 32'hFFFF_FFFC;
        #1;
        check_eq("wrap_pc", pc_next_o, 32'h0);
        ex_valid_i = 1'b1; ex_pc_i = 32'hFFFF_FFFC;
        ex_taken_i = 1'b0; ex_pred_i = 1'b1;
        #1;
        check_eq("wrap_recover", pc_next_o, 32'h0);
        ex_valid_i = 1'b0;
        pc_i = 32'h44;

        // Asynchronous reset pulse between edges
        @(negedge clk_i);
        lookup(32'h40, 32'h80);
        check_eq("pre_midrst_pred", 32'(pred_taken_o), 32'd1);
        #1 rst_n_i = 1'b0;
        #1;
        check_eq("midrst_pred", 32'(pred_taken_o), 32'd0);
        rst_n_i = 1'b1;
        #1;
        check_eq("midrst_release_pred", 32'(pred_taken_o), 32'd0);
        lookup(32'h20, 32'h400);
        check_eq("midrst_other_entry", 32'(pred_taken_o), 32'd0);
        id_branch_i = 1'b0;
        ex_update(32'h40, 1'b1);
        lookup(32'h40, 32'h80);
        check_eq("midrst_retrain", 32'(pred_taken_o), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
